tb_refill_ctl: RTL and testbench
================================

Name: tb_refill_ctl

Overview:
- Translation-buffer miss/refill sequencer; sits directly downstream of the TB array and consumes its hit and parity outputs.
- On a miss it computes the system PTE address from the base and length registers and fetches the PTE over a req/rdy handshake.
- It checks the PTE, presents it on the refill PAD bus with pte_check_l low, then writes one TB group chosen by a victim bit.
- Reports length, invalid, memory, timeout and TB-parity faults to the microsequencer.

Parameters:
- TIMEOUT_CYC, 255: cycles the PTE request may wait for pte_rdy_h before a timeout fault; legal range 1..255.
- TMO_W, 8: width of the timeout counter.

Ports:
- b_clk_l  in  1  block clock; all state changes on its rising edge.
- reset_h  in  1  synchronous reset, active-high.
- tb_lookup_h  in  1  a translation is requested this cycle.
- va_h  in  23  virtual address bits [31:9].
- tb_hit_h  in  2  per-group hit from the TB, valid in the same cycle as the lookup.
- tb_tag_perr_h  in  2  per-group tag parity error.
- tb_data_perr_h  in  1  TB data parity error.
- sbr_h  in  24  system base register (byte address).
- slr_h  in  21  system length register (PTE count).
- pte_rdy_h  in  1  memory accepts the request; pte_data_h and pte_err_h are valid in this cycle.
- pte_data_h  in  32  PTE: [31] V, [30:27] PROT, [26] M, [14:0] PFN.
- pte_err_h  in  1  memory read error.
- pte_req_h  out  1  PTE read request.
- pte_addr_h  out  24  PTE physical address.
- refill_pad_h  out  24  PAD-format entry driven to the TB.
- pte_check_l  out  1  low selects PTE-check path in the TB.
- tb_grp_wr_h  out  2  one-hot TB group write strobe.
- tb_busy_h  out  1  sequencer is not idle.
- done_h  out  1  one-cycle pulse: refill complete.
- fault_h  out  1  one-cycle pulse: refill aborted.
- fault_code_h  out  3  fault reason, held until the next accepted lookup.

Behaviour:
- States: IDLE, LEN, REQ, CHECK, WRITE, FAULT.
- Reset values: state=IDLE; victim=0; all outputs 0 except pte_check_l=1; fault_code_h=000; timeout counter=0.
- IDLE, tb_lookup_h=1 (lookup accepted, fault_code_h cleared to 000):
  - tb_hit_h==11, any tb_tag_perr_h, or (single hit and tb_data_perr_h) → FAULT, code 101.
  - Clean single hit → stay IDLE, no outputs change.
  - tb_hit_h==00 → latch va_h → LEN.
- Lookups while tb_busy_h=1 are ignored (no latch, no effect on state).
- LEN (1 cycle):
  - VPN = va[29:9] (21 bits). If VPN >= slr_h → FAULT, code 001.
  - Otherwise pte_addr_h = (sbr_h + {VPN,2'b00}) mod 2^24, registered → REQ.
- REQ:
  - pte_req_h=1 and pte_addr_h stable.
  - Transfer when pte_req_h and pte_rdy_h are both high; capture pte_data_h.
  - pte_err_h at transfer → FAULT, code 011.
  - Otherwise → CHECK.
  - Counter increments each cycle without rdy; reaching TIMEOUT_CYC → FAULT, code 100, pte_req_h dropped.
- CHECK (1 cycle):
  - pte_check_l=0.
  - refill_pad_h = {PFN[14:0], V, PROT[3:0], M, 3'b000}.
  - V=0 → FAULT, code 010, no write.
  - Else → WRITE.
- WRITE (1 cycle):
  - tb_grp_wr_h = victim ? 10 : 01; refill_pad_h held.
  - Victim toggles at exit; done_h pulses with the IDLE transition.
- FAULT (1 cycle): fault_h=1 → IDLE.
- tb_busy_h=1 in every state except IDLE.
- Miss latency with immediate rdy: lookup N, LEN N+1, REQ N+2, CHECK N+3, WRITE N+4, done_h N+5.
- Reset mid-operation: next edge returns to IDLE; pte_req_h and tb_grp_wr_h are low that cycle; victim is cleared.

Optional Feature:
- Macro TB_REFILL_MISS_CNT_EN.
- Defined: adds output miss_cnt_h[15:0].
  - Increments on each lookup that enters LEN.
  - Saturates at FFFF; reset to 0.
  - Cleared by input miss_cnt_clr_h; clear wins over a simultaneous increment.
- Undefined: the port and the counter are absent.

Test Plan:
- Reset, then lookup with tb_hit_h=01, no perr → tb_busy_h stays 0, no pte_req_h, fault_h 0.
- Miss with va[29:9]=5, sbr=000400, slr=100, rdy same cycle, pte=0x80000123 → pte_addr=000414; refill_pad=0x024700 (PFN 0x123 at [23:9], V bit [8] set, PROT and M zero); tb_grp_wr=01 at N+4; done_h at N+5. A second miss writes 10.
- Miss with VPN=slr → fault_h pulse, code 001, no pte_req_h.
- Miss with pte[31]=0 → pte_check_l low one cycle, code 010, tb_grp_wr stays 00. Repeat with pte_err_h=1 → code 011.
- Miss with pte_rdy_h held low → pte_req_h high for 255 cycles, then code 100. Assert reset_h mid-REQ → pte_req_h low the next cycle.
- Lookup with tb_hit_h=11, then with tb_tag_perr_h=10 → code 101 each time. With the macro defined: 3 misses → miss_cnt_h=3; clr asserted with a simultaneous miss → 0.

Source files
------------

// File: rtl/tb_refill_ctl_if.sv
// tb_refill_ctl_if: lookup, PTE fetch and refill signals of tb_refill_ctl; the miss counter pair exists only under TB_REFILL_MISS_CNT_EN
interface tb_refill_ctl_if;
  logic        tb_lookup_h;
  logic [22:0] va_h;
  logic [1:0]  tb_hit_h;
  logic [1:0]  tb_tag_perr_h;
  logic        tb_data_perr_h;
  logic [23:0] sbr_h;
  logic [20:0] slr_h;
  logic        pte_rdy_h;
  logic [31:0] pte_data_h;
  logic        pte_err_h;
  logic        pte_req_h;
  logic [23:0] pte_addr_h;
  logic [23:0] refill_pad_h;
  logic        pte_check_l;
  logic [1:0]  tb_grp_wr_h;
  logic        tb_busy_h;
  logic        done_h;
  logic        fault_h;
  logic [2:0]  fault_code_h;
`ifdef TB_REFILL_MISS_CNT_EN
  logic        miss_cnt_clr_h;
  logic [15:0] miss_cnt_h;
`endif
  modport master (
    input  tb_lookup_h, va_h, tb_hit_h, tb_tag_perr_h, tb_data_perr_h, sbr_h, slr_h,
           pte_rdy_h, pte_data_h, pte_err_h,
    output pte_req_h, pte_addr_h, refill_pad_h, pte_check_l, tb_grp_wr_h, tb_busy_h,
           done_h, fault_h, fault_code_h
`ifdef TB_REFILL_MISS_CNT_EN
    , input miss_cnt_clr_h, output miss_cnt_h
`endif
  );
  modport slave (
    output tb_lookup_h, va_h, tb_hit_h, tb_tag_perr_h, tb_data_perr_h, sbr_h, slr_h,
           pte_rdy_h, pte_data_h, pte_err_h,
    input  pte_req_h, pte_addr_h, refill_pad_h, pte_check_l, tb_grp_wr_h, tb_busy_h,
           done_h, fault_h, fault_code_h
`ifdef TB_REFILL_MISS_CNT_EN
    , output miss_cnt_clr_h, input miss_cnt_h
`endif
  );
endinterface

// File: rtl/tb_refill_ctl.sv
// tb_refill_ctl: TB miss/refill sequencer (length check, PTE fetch, check, group write); TB_REFILL_MISS_CNT_EN adds a saturating miss counter
module tb_refill_ctl #(
  parameter int TIMEOUT_CYC = 255,
  parameter int TMO_W = 8
) (
  input logic b_clk_l,
  input logic reset_h,
  tb_refill_ctl_if.master bus
);
  typedef enum logic [2:0] {IDLE, LEN, REQ, CHECK, WRITE, FAULT} state_t;
  state_t state, state_nx;
  logic [20:0] vpn;
  logic [TMO_W-1:0] tmo;
  logic victim;
  logic [2:0] code_nx;
  logic lookup_bad, xfer, tmo_hit, len_bad;
  assign lookup_bad = (&bus.tb_hit_h) | (|bus.tb_tag_perr_h) | ((^bus.tb_hit_h) & bus.tb_data_perr_h);
  assign xfer = state == REQ && bus.pte_rdy_h;
  assign tmo_hit = state == REQ && !bus.pte_rdy_h && tmo == TMO_W'(TIMEOUT_CYC - 1);
  assign len_bad = vpn >= bus.slr_h;
  always_comb begin
    state_nx = state;
    code_nx = bus.fault_code_h;
    case (state)
      IDLE: if (bus.tb_lookup_h) begin
        code_nx = lookup_bad ? 3'b101 : 3'b000;
        state_nx = lookup_bad ? FAULT : (bus.tb_hit_h == 2'b00 ? LEN : IDLE);
      end
      LEN: begin
        state_nx = len_bad ? FAULT : REQ;
        code_nx = len_bad ? 3'b001 : code_nx;
      end
      REQ: if (xfer) begin
        state_nx = bus.pte_err_h ? FAULT : CHECK;
        code_nx = bus.pte_err_h ? 3'b011 : code_nx;
      end else if (tmo_hit) begin
        state_nx = FAULT;
        code_nx = 3'b100;
      end
      CHECK: begin
        state_nx = bus.refill_pad_h[8] ? WRITE : FAULT;
        code_nx = bus.refill_pad_h[8] ? code_nx : 3'b010;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge b_clk_l) begin
    if (reset_h) begin
      state <= IDLE;
      vpn <= '0;
      tmo <= '0;
      victim <= 1'b0;
      bus.pte_addr_h <= '0;
      bus.refill_pad_h <= '0;
      bus.fault_code_h <= '0;
      bus.done_h <= 1'b0;
    end else begin
      state <= state_nx;
      bus.fault_code_h <= code_nx;
      bus.done_h <= state == WRITE;
      if (state == IDLE && state_nx == LEN) vpn <= bus.va_h[20:0];
      if (state == LEN) bus.pte_addr_h <= bus.sbr_h + 24'({vpn, 2'b00});
      tmo <= (state == REQ && !bus.pte_rdy_h) ? tmo + TMO_W'(1) : '0;
      if (xfer && !bus.pte_err_h)
        bus.refill_pad_h <= {bus.pte_data_h[14:0], bus.pte_data_h[31], bus.pte_data_h[30:27], bus.pte_data_h[26], 3'b000};
      if (state == WRITE) victim <= !victim;
    end
  end
  assign bus.pte_req_h = state == REQ;
  assign bus.pte_check_l = state != CHECK;
  assign bus.tb_grp_wr_h = state == WRITE ? (victim ? 2'b10 : 2'b01) : 2'b00;
  assign bus.tb_busy_h = state != IDLE;
  assign bus.fault_h = state == FAULT;
`ifdef TB_REFILL_MISS_CNT_EN
  always_ff @(posedge b_clk_l) begin
    if (reset_h || bus.miss_cnt_clr_h) bus.miss_cnt_h <= '0;
    else if (state == IDLE && state_nx == LEN && !(&bus.miss_cnt_h)) bus.miss_cnt_h <= bus.miss_cnt_h + 16'd1;
  end
`endif
endmodule

// File: tb/tb_tb_refill_ctl.sv
// tb_tb_refill_ctl: vector table plus scoreboard for tb_refill_ctl; hand sequences cover timeout, busy lookups, reset mid-REQ and the miss counter
module tb_tb_refill_ctl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  tb_refill_ctl_if bus ();
  tb_refill_ctl dut (.b_clk_l(clk), .reset_h(rst), .bus(bus));
  typedef enum int {EV_NONE, EV_DONE, EV_FAULT} ev_t;
  typedef struct {
    logic [1:0]  hit;
    logic [1:0]  tperr;
    logic        dperr;
    logic [20:0] vpn;
    logic [23:0] sbr;
    logic [20:0] slr;
    logic [31:0] pte;
    logic        perr;
    ev_t         ev;
    logic [2:0]  code;
    logic [23:0] addr;
    logic [23:0] pad;
  } vec_t;
  vec_t vt[14];
  vec_t sb[$];
  int n_vec = 0;
  int n_bad = 0;
  logic exp_victim = 1'b0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bus.tb_lookup_h = 0; bus.va_h = '0; bus.tb_hit_h = '0; bus.tb_tag_perr_h = '0;
    bus.tb_data_perr_h = 0; bus.sbr_h = '0; bus.slr_h = '0; bus.pte_rdy_h = 0;
    bus.pte_data_h = '0; bus.pte_err_h = 0;
`ifdef TB_REFILL_MISS_CNT_EN
    bus.miss_cnt_clr_h = 0;
`endif
  endtask
  task automatic drive_lookup(input vec_t v, input logic rdy);
    bus.tb_lookup_h = 1; bus.tb_hit_h = v.hit; bus.tb_tag_perr_h = v.tperr;
    bus.tb_data_perr_h = v.dperr; bus.va_h = {2'b11, v.vpn}; bus.sbr_h = v.sbr;
    bus.slr_h = v.slr; bus.pte_rdy_h = rdy; bus.pte_data_h = v.pte; bus.pte_err_h = v.perr;
  endtask
  task automatic run_vec(input vec_t v, input string nm);
    vec_t e;
    ev_t ev = EV_NONE;
    int ev_k = 0, grp_k = 0, req_n = 0, chk_n = 0, busy_n = 0;
    logic [1:0] grp = 2'b00;
    logic exp_req, exp_chk;
    sb.push_back(v);
    drive_lookup(v, 1'b1);
    tick;
    bus.tb_lookup_h = 0;
    for (int k = 1; k <= 12; k++) begin
      if (bus.tb_busy_h) busy_n++;
      if (bus.pte_req_h) begin
        req_n++;
        chk({nm, ":addr"}, 32'(bus.pte_addr_h), 32'(v.addr));
      end
      if (!bus.pte_check_l) begin
        chk_n++;
        chk({nm, ":pad"}, 32'(bus.refill_pad_h), 32'(v.pad));
      end
      if (bus.tb_grp_wr_h != 2'b00) begin
        grp = bus.tb_grp_wr_h;
        grp_k = k;
      end
      if (bus.done_h || bus.fault_h) begin
        ev = bus.done_h ? EV_DONE : EV_FAULT;
        ev_k = k;
        break;
      end
      tick;
    end
    e = sb.pop_front();
    exp_req = e.ev != EV_NONE && e.code != 3'b001 && e.code != 3'b101;
    exp_chk = e.ev == EV_DONE || e.code == 3'b010;
    chk({nm, ":event"}, 32'(ev), 32'(e.ev));
    chk({nm, ":code"}, 32'(bus.fault_code_h), 32'(e.code));
    chk({nm, ":req_cycles"}, 32'(req_n), 32'(exp_req));
    chk({nm, ":check_cycles"}, 32'(chk_n), 32'(exp_chk));
    if (e.ev == EV_DONE) begin
      chk({nm, ":done_cycle"}, 32'(ev_k), 32'd5);
      chk({nm, ":grp_cycle"}, 32'(grp_k), 32'd4);
      chk({nm, ":grp_wr"}, 32'(grp), exp_victim ? 32'd2 : 32'd1);
      exp_victim = !exp_victim;
    end else begin
      chk({nm, ":grp_wr"}, 32'(grp), 32'd0);
    end
    if (e.ev == EV_NONE) chk({nm, ":busy"}, 32'(busy_n), 32'd0);
    tick;
    idle_inputs;
  endtask
  initial begin
    vt[0]  = '{2'b01, 2'b00, 1'b0, 21'h5,      24'h000400, 21'h100,    32'h80000123, 1'b0, EV_NONE,  3'b000, 24'h0,      24'h0};
    vt[1]  = '{2'b00, 2'b00, 1'b0, 21'h5,      24'h000400, 21'h100,    32'h80000123, 1'b0, EV_DONE,  3'b000, 24'h000414, 24'h024700};
    vt[2]  = '{2'b00, 2'b00, 1'b0, 21'h10,     24'hFFFFF0, 21'h100,    32'hF4007FFF, 1'b0, EV_DONE,  3'b000, 24'h000030, 24'hFFFFE8};
    vt[3]  = '{2'b00, 2'b00, 1'b0, 21'h100,    24'h000400, 21'h100,    32'h80000123, 1'b0, EV_FAULT, 3'b001, 24'h0,      24'h0};
    vt[4]  = '{2'b00, 2'b00, 1'b0, 21'hFF,     24'h000000, 21'h100,    32'h80000001, 1'b0, EV_DONE,  3'b000, 24'h0003FC, 24'h000300};
    vt[5]  = '{2'b00, 2'b00, 1'b0, 21'h1,      24'h001000, 21'h10,     32'h7FFFFFFF, 1'b0, EV_FAULT, 3'b010, 24'h001004, 24'hFFFEF8};
    vt[6]  = '{2'b00, 2'b00, 1'b0, 21'h2,      24'h002000, 21'h10,     32'h80000005, 1'b1, EV_FAULT, 3'b011, 24'h002008, 24'h0};
    vt[7]  = '{2'b11, 2'b00, 1'b0, 21'h2,      24'h002000, 21'h10,     32'h80000005, 1'b0, EV_FAULT, 3'b101, 24'h0,      24'h0};
    vt[8]  = '{2'b00, 2'b10, 1'b0, 21'h2,      24'h002000, 21'h10,     32'h80000005, 1'b0, EV_FAULT, 3'b101, 24'h0,      24'h0};
    vt[9]  = '{2'b10, 2'b00, 1'b1, 21'h2,      24'h002000, 21'h10,     32'h80000005, 1'b0, EV_FAULT, 3'b101, 24'h0,      24'h0};
    vt[10] = '{2'b10, 2'b00, 1'b0, 21'h2,      24'h002000, 21'h10,     32'h80000005, 1'b0, EV_NONE,  3'b000, 24'h0,      24'h0};
    vt[11] = '{2'b00, 2'b00, 1'b1, 21'h3,      24'h000000, 21'h8,      32'h80000002, 1'b0, EV_DONE,  3'b000, 24'h00000C, 24'h000500};
    vt[12] = '{2'b00, 2'b00, 1'b0, 21'h1FFFFF, 24'h000000, 21'h1FFFFF, 32'h80000002, 1'b0, EV_FAULT, 3'b001, 24'h0,      24'h0};
    vt[13] = '{2'b00, 2'b00, 1'b0, 21'h4,      24'h000000, 21'h10,     32'h80000002, 1'b0, EV_NONE,  3'b000, 24'h0,      24'h0};
    idle_inputs;
    tick;
    tick;
    chk("rst:busy", 32'(bus.tb_busy_h), 32'd0);
    chk("rst:req", 32'(bus.pte_req_h), 32'd0);
    chk("rst:check_l", 32'(bus.pte_check_l), 32'd1);
    chk("rst:grp_wr", 32'(bus.tb_grp_wr_h), 32'd0);
    chk("rst:done_fault", {30'd0, bus.done_h, bus.fault_h}, 32'd0);
    chk("rst:code", 32'(bus.fault_code_h), 32'd0);
    chk("rst:addr_pad", {bus.pte_addr_h[7:0], bus.refill_pad_h}, 32'd0);
    rst = 0;
    tick;
    for (int i = 0; i < 13; i++) run_vec(vt[i], $sformatf("vec%0d", i));
    begin : timeout_seq
      int req_n = 0;
      bit got = 0;
      drive_lookup(vt[13], 1'b0);
      tick;
      bus.tb_hit_h = 2'b11;
      for (int k = 1; k <= 400; k++) begin
        if (bus.pte_req_h) req_n++;
        if (bus.fault_h) begin
          got = 1;
          break;
        end
        tick;
      end
      bus.tb_lookup_h = 0;
      chk("tmo:fault_seen", 32'(got), 32'd1);
      chk("tmo:req_cycles", 32'(req_n), 32'd255);
      chk("tmo:code", 32'(bus.fault_code_h), 32'd4);
      chk("tmo:req_at_fault", 32'(bus.pte_req_h), 32'd0);
      tick;
      chk("tmo:fault_pulse", 32'(bus.fault_h), 32'd0);
      idle_inputs;
    end
    run_vec(vt[1], "pre_rst");
    drive_lookup(vt[13], 1'b0);
    tick;
    bus.tb_lookup_h = 0;
    tick;
    tick;
    chk("midrst:req_before", 32'(bus.pte_req_h), 32'd1);
    rst = 1;
    tick;
    chk("midrst:req", 32'(bus.pte_req_h), 32'd0);
    chk("midrst:busy", 32'(bus.tb_busy_h), 32'd0);
    chk("midrst:grp_wr", 32'(bus.tb_grp_wr_h), 32'd0);
    rst = 0;
    exp_victim = 1'b0;
    idle_inputs;
    tick;
    run_vec(vt[1], "post_rst");
`ifdef TB_REFILL_MISS_CNT_EN
    bus.miss_cnt_clr_h = 1;
    tick;
    bus.miss_cnt_clr_h = 0;
    chk("cnt:clr", 32'(bus.miss_cnt_h), 32'd0);
    for (int i = 0; i < 3; i++) run_vec(vt[1], $sformatf("cnt%0d", i));
    chk("cnt:three", 32'(bus.miss_cnt_h), 32'd3);
    drive_lookup(vt[3], 1'b1);
    bus.miss_cnt_clr_h = 1;
    tick;
    idle_inputs;
    chk("cnt:clr_wins", 32'(bus.miss_cnt_h), 32'd0);
    tick;
    tick;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
